// File: rtl/pio_out_pulse_pkg.sv
// -----------------------------------------------------------------------------
// pio_out_pulse_pkg
// Shared definitions for the pulse-capable output PIO slave:
//   - word register offsets on the Avalon-MM slave port
//   - state encoding of the pulse timer FSM
// -----------------------------------------------------------------------------
package pio_out_pulse_pkg;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
   localparam logic [2:0] ADDR_OUTSET    = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
   localparam logic [2:0] ADDR_PULSE     = 3'd6;
   localparam logic [2:0] ADDR_STATUS    = 3'd7;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } pulse_state_t;

endpackage

// File: rtl/pio_pulse_timer.sv
// -----------------------------------------------------------------------------
// pio_pulse_timer
// Pulse FSM, length counter and inversion mask for pio_out_pulse.
// A start request in IDLE captures the mask and loads the counter with len
// (len of 0 is treated as 1); the mask is held for exactly that many cycles
// and then cleared. Start requests while ACTIVE are ignored.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : arm request (caller guarantees start_mask is nonzero)
//   start_mask  : bits to invert for the duration of the pulse
//   len         : pulse length in clk cycles
//   mask        : current inversion mask, 0 whenever IDLE
//   busy        : high while the pulse is in progress
// -----------------------------------------------------------------------------
module pio_pulse_timer
   import pio_out_pulse_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] start_mask,
   input  logic [CNT_WIDTH-1:0]  len,
   output logic [DATA_WIDTH-1:0] mask,
   output logic                  busy
);

   pulse_state_t          r_state;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] r_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_mask  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= ACTIVE;
                  r_mask  <= start_mask;
                  r_cnt   <= (len == '0) ? CNT_WIDTH'(1) : len;
               end
            end
            ACTIVE: begin
               // cnt holds the number of cycles still to run including this one
               if (r_cnt == CNT_WIDTH'(1)) begin
                  r_state <= IDLE;
                  r_mask  <= '0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - CNT_WIDTH'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_mask  <= '0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign mask = r_mask;
   assign busy = (r_state == ACTIVE);

endmodule

// File: rtl/pio_out_pulse.sv
// -----------------------------------------------------------------------------
// pio_out_pulse
// Output-only PIO slave on Avalon-MM with a DATA register, atomic bit
// set/clear registers and an optional timed pulse mode that inverts selected
// output bits for a programmable number of cycles.
//
// Optional feature macro: PIO_OUT_PULSE_EN
//   defined   : PULSE_LEN (1), PULSE (6) and STATUS (7) are implemented and
//               out_port = DATA ^ mask
//   undefined : no timer is built; addresses 1, 6, 7 read 0, writes ignored,
//               out_port = DATA
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   address     : word register offset
//   chipselect  : slave select
//   write_n     : active-low write strobe
//   writedata   : write data, bits above register width ignored
//   readdata    : combinational, zero-extended read data
//   out_port    : output pins
// -----------------------------------------------------------------------------
module pio_out_pulse
   import pio_out_pulse_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   logic                  w_wr;
   logic [DATA_WIDTH-1:0] w_wd;
   logic                  w_unused_wd;
   logic [DATA_WIDTH-1:0] r_data;

   assign w_wr = chipselect && !write_n;
   assign w_wd = writedata[DATA_WIDTH-1:0];
   // upper writedata bits are intentionally dropped
   assign w_unused_wd = ^writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data <= RESET_VALUE;
      end else if (w_wr) begin
         case (address)
            ADDR_DATA:     r_data <= w_wd;
            ADDR_OUTSET:   r_data <= r_data | w_wd;
            ADDR_OUTCLEAR: r_data <= r_data & ~w_wd;
            default:       ;
         endcase
      end
   end

`ifdef PIO_OUT_PULSE_EN
   logic [CNT_WIDTH-1:0]  r_pulse_len;
   logic                  w_start;
   logic [DATA_WIDTH-1:0] w_mask;
   logic                  w_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pulse_len <= CNT_WIDTH'(1);
      end else if (w_wr && (address == ADDR_PULSE_LEN)) begin
         r_pulse_len <= writedata[CNT_WIDTH-1:0];
      end
   end

   // zero-mask PULSE writes never reach the timer; busy drops are in the timer
   assign w_start = w_wr && (address == ADDR_PULSE) && (w_wd != '0);

   pio_pulse_timer #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .start      (w_start),
      .start_mask (w_wd),
      .len        (r_pulse_len),
      .mask       (w_mask),
      .busy       (w_busy)
   );

   assign out_port = r_data ^ w_mask;

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:      readdata[DATA_WIDTH-1:0] = r_data;
         ADDR_PULSE_LEN: readdata[CNT_WIDTH-1:0]  = r_pulse_len;
         ADDR_PULSE:     readdata[DATA_WIDTH-1:0] = w_mask;
         ADDR_STATUS:    readdata[0]              = w_busy;
         default:        ;
      endcase
   end
`else
   localparam int unused_cnt_w = CNT_WIDTH;

   assign out_port = r_data;

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA: readdata[DATA_WIDTH-1:0] = r_data;
         default:   ;
      endcase
   end
`endif

endmodule

// File: doc/pio_out_pulse.md
# pio_out_pulse

Parametrised output-only PIO slave on the Avalon-MM bus, successor to the fixed 8-bit output port. It drives a `DATA_WIDTH`-bit `out_port` from a data register and adds atomic bit set/clear registers. It also adds a timed pulse mode: selected bits are inverted for a programmable number of clock cycles, then revert. It sits beside the other PIO slaves in the system interconnect and drives the serial genetic-circuit control lines.

## Interface
- `DATA_WIDTH`, 8 — output port width, 1..32.
- `RESET_VALUE`, 0 — `out_port`/DATA value after reset.
- `CNT_WIDTH`, 16 — pulse length counter width, 1..32.

- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high reset, sampled on rising `clk`.
- `address` in 3 — word register offset.
- `chipselect` in 1 — slave select.
- `write_n` in 1 — active-low write strobe.
- `writedata` in 32 — write data; bits above the register width are ignored.
- `readdata` out 32 — read data, zero-extended.
- `out_port` out `DATA_WIDTH` — output pins.

## Operation
- A write occurs when `chipselect && !write_n`, with effect at the next rising `clk`.
- Register map:
  - 0 DATA: R/W.
  - 1 PULSE_LEN: R/W, `CNT_WIDTH` bits.
  - 2, 3: reserved; read 0, writes ignored.
  - 4 OUTSET: W; DATA |= wd. Reads 0.
  - 5 OUTCLEAR: W; DATA &= ~wd. Reads 0.
  - 6 PULSE: W; arms a pulse. Reads back the current mask.
  - 7 STATUS: RO; bit0 = busy, other bits 0.
- `out_port = DATA ^ mask`. `mask` is 0 whenever the FSM is IDLE.
- Pulse FSM states:
  - IDLE → ACTIVE on a PULSE write with nonzero `wd[DATA_WIDTH-1:0]`. On that edge, capture `mask = wd` and load `cnt = (PULSE_LEN==0) ? 1 : PULSE_LEN`.
  - ACTIVE: `cnt` decrements each cycle. When `cnt==1`, the next edge returns to IDLE and clears `mask`.
- A PULSE write with a zero mask is ignored.
- A PULSE write while ACTIVE is dropped. The mask and count are unchanged, and no error is raised.
- DATA, OUTSET and OUTCLEAR writes during ACTIVE update DATA immediately. `out_port` reflects `new DATA ^ mask`.
- A PULSE_LEN write during ACTIVE affects only the next pulse.
- If the pulse ends and a DATA write lands in the same cycle, both apply: `out_port = new DATA` on the next cycle.
- Reset mid-pulse: the FSM aborts to IDLE, `mask = 0`, DATA = `RESET_VALUE`.

## Timing
- `readdata` is combinational from `address` and the registers: zero wait states, zero read latency.
- A write changes `out_port` one cycle after the write edge (registered).
- A pulse of length N (N ≥ 1) inverts the masked bits for exactly N `clk` cycles, starting the cycle after the PULSE write edge. PULSE_LEN = 0 behaves as N = 1.
- STATUS.busy is high for exactly those N cycles.
- Reset values:
  - `out_port` = `RESET_VALUE`
  - `readdata` = value of the addressed register after reset, e.g. DATA at address 0
  - PULSE_LEN = 1, mask = 0, cnt = 0, state IDLE.

## Configuration
- `PIO_OUT_PULSE_EN`:
  - Defined: PULSE_LEN, PULSE and STATUS behave as above.
  - Undefined: the FSM, counter and mask are not built. Addresses 1, 6 and 7 read 0 and ignore writes, and `out_port = DATA`. DATA, OUTSET and OUTCLEAR are unaffected.

## Structure
- Shared package `pio_out_pulse_pkg` holds:
  - register offset constants: `ADDR_DATA`, `ADDR_PULSE_LEN`, `ADDR_OUTSET`, `ADDR_OUTCLEAR`, `ADDR_PULSE`, `ADDR_STATUS`
  - the FSM state enum `pulse_state_t` (IDLE, ACTIVE).
- One sub-module, `pio_pulse_timer`, holds the FSM, counter and mask register. Its inputs are `start`, `start_mask` and `len`; its outputs are `mask` and `busy`. The top level holds the register file and read mux.

## Test plan
- Reset with `RESET_VALUE=8'hA5`: `out_port=8'hA5`, STATUS=0, PULSE_LEN reads 1.
- Write DATA=`0x3C`, OUTSET=`0x81`, OUTCLEAR=`0x0C`: `out_port` steps `0x3C`→`0xBD`→`0xB1`, each change one cycle after its write. OUTSET/OUTCLEAR read 0.
- PULSE_LEN=5, DATA=`0x00`, PULSE=`0x03`: `out_port=0x03` for exactly 5 cycles, then `0x00`; busy is high for the same 5 cycles.
- During a 10-cycle pulse with mask `0x01`, write PULSE=`0xF0`, then DATA=`0x10`:
  - the PULSE write is dropped (mask stays `0x01`)
  - `out_port=0x11` until the pulse ends, then `0x10`.
- PULSE_LEN=0 with mask `0x80`: one-cycle inversion. Write PULSE=0: no activity.
- Assert `reset` on cycle 3 of an 8-cycle pulse: the next cycle has `out_port=RESET_VALUE` and busy=0. Repeat with `PIO_OUT_PULSE_EN` undefined: PULSE writes have no effect and addresses 1, 6, 7 read 0.
